cond_issue_queue: RTL and testbench
===================================

COND_ISSUE_QUEUE -- requirements
Module: cond_issue_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width (>= 8).
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries (power of 2, >= 2).
REQ-003 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 SHALL have parameter NV_PASS, default 0; 1 = cond 4'b1111 issues, 0 = cond 4'b1111 is dropped.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, fetch offers word.
REQ-008 SHALL have port in_ready, output, 1, queue accepts word.
REQ-009 SHALL have port in_data, input, DATA_W, fetched instruction; cond field = in_data[DATA_W-1:DATA_W-4].
REQ-010 SHALL have port out_valid, output, 1, head instruction passes condition and is offered to decode.
REQ-011 SHALL have port out_ready, input, 1, decode accepts.
REQ-012 SHALL have port out_data, output, DATA_W, head instruction.
REQ-013 SHALL have port cpsr, input, 32, flags N=31, Z=30, C=29, V=28.
REQ-014 SHALL have port flags_pending, input, 1, an in-flight instruction will update flags; stalls condition evaluation.
REQ-015 SHALL have port flush, input, 1, discard all buffered words.
REQ-016 SHALL have port issued_cnt, output, CNT_W, instructions handed to decode.
REQ-017 SHALL have port skipped_cnt, output, CNT_W, instructions dropped on failed condition.

Function
REQ-018 SHALL store words in a DEPTH-entry circular FIFO (wr/rd pointers plus count); push on in_valid & in_ready.
REQ-019 SHALL drive in_ready = (count != DEPTH) & !flush; no push-through when full, even if head leaves in the same cycle.
REQ-020 SHALL evaluate head cond against cpsr: EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 true; NV 1111 = NV_PASS.
REQ-021 SHALL evaluate only when count != 0 and flags_pending = 0; otherwise out_valid = 0 and nothing pops.
REQ-022 SHALL drive out_valid = evaluated & pass; out_data = head entry, stable while out_valid & !out_ready.
REQ-023 SHALL pop and increment issued_cnt on out_valid & out_ready.
REQ-024 SHALL pop without handshake and increment skipped_cnt when evaluated & !pass; one skip per cycle maximum.
REQ-025 SHALL give minimum latency of 1 cycle: word pushed at edge k can be issued or skipped in cycle k+1.
REQ-026 SHALL allow simultaneous push and pop in one cycle, count unchanged.
REQ-027 SHALL, on flush = 1, empty the FIFO at the next edge, suppress out_valid and skip that cycle, and ignore in_valid; counters hold.
REQ-028 SHALL wrap pointers modulo DEPTH and counters modulo 2^CNT_W.
REQ-029 SHALL sample cpsr each evaluation cycle; an out_valid head whose condition turns false before acceptance drops out_valid and is skipped.

Reset
REQ-030 SHALL, on reset low, asynchronously clear pointers, count, issued_cnt and skipped_cnt; out_valid = 0, in_ready = 0 while reset is low, in_ready = 1 on the first cycle after release; FIFO storage need not clear, out_data = 0 while empty.
REQ-031 SHALL, on reset mid-operation, discard all buffered words with no partial handshake completed.

Structure
REQ-032 SHALL place cond encodings (localparam/enum), flag bit indices N/Z/C/V and the condition-pass function in shared package issue_pkg.
REQ-033 SHALL implement condition evaluation in combinational sub-module cond_check (cond, flags, NV_PASS -> pass).

Verification
REQ-034 SHALL cover: cpsr=0x4000_0000, push 0x0xxxxxxx (EQ) then 0x1xxxxxxx (NE) -> EQ issued, NE skipped; issued=1, skipped=1.
REQ-035 SHALL cover: out_ready=0, push 5 words with DEPTH=4 -> in_ready low after 4; 5th accepted only after first issue.
REQ-036 SHALL cover: flags_pending=1 with AL word queued -> out_valid=0 until flags_pending=0, then issued next cycle.
REQ-037 SHALL cover: 3 words buffered, flush=1 one cycle -> count 0, out_valid=0 next cycle, counters unchanged.
REQ-038 SHALL cover: NV_PASS=0 vs 1 with 0xFxxxxxxx -> skipped vs issued; all 16 conds swept against all 16 NZCV combinations versus a reference table.
REQ-039 SHALL cover: reset asserted with 2 words queued and out_valid high -> out_valid=0 immediately, counters 0, normal issue after release.

Source files
------------

// File: rtl/issue_pkg.sv
`default_nettype none
// ============================================================================
// issue_pkg : condition codes, CPSR flag positions and the condition-pass rule
// Rev 1.0
// ============================================================================
package issue_pkg;

  localparam int N_BIT = 31;
  localparam int Z_BIT = 30;
  localparam int C_BIT = 29;
  localparam int V_BIT = 28;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  function automatic logic cond_pass(input logic [3:0] cond,
                                     input logic n, input logic z,
                                     input logic c, input logic v,
                                     input logic nv_pass);
    logic pass;
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = nv_pass;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// cond_check : combinational condition evaluation against NZCV flags
// Rev 1.0
// ============================================================================
module cond_check
  import issue_pkg::*;
#(
  parameter bit NV_PASS = 1'b0
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags,   // {N, Z, C, V}
  output logic       pass
);

  assign pass = cond_pass(cond, flags[3], flags[2], flags[1], flags[0], NV_PASS);

endmodule
`default_nettype wire

// File: rtl/cond_issue_queue.sv
`default_nettype none
// ============================================================================
// cond_issue_queue : instruction FIFO that issues or skips the head word
//                    according to its condition field and the current CPSR
// Rev 1.0
// ============================================================================
module cond_issue_queue
  import issue_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter bit NV_PASS = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic [31:0]       cpsr,
  input  logic              flags_pending,
  input  logic              flush,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  skipped_cnt
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic              empty;
  logic              full;
  logic              evaluate;
  logic              pass;
  logic              skip;
  logic              issue;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [3:0]        flags;
  logic              unused_cpsr_bits;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign head     = mem[rd_ptr];
  assign flags    = {cpsr[N_BIT], cpsr[Z_BIT], cpsr[C_BIT], cpsr[V_BIT]};
  assign unused_cpsr_bits = ^cpsr[27:0];

  cond_check #(
    .NV_PASS (NV_PASS)
  ) u_cond_check (
    .cond  (head[DATA_W-1 -: 4]),
    .flags (flags),
    .pass  (pass)
  );

  // A flush cycle neither issues nor skips, so evaluation is masked by it too.
  assign evaluate  = !empty && !flags_pending && !flush;
  assign out_valid = evaluate && pass;
  assign skip      = evaluate && !pass;
  assign issue     = out_valid && out_ready;
  assign pop       = issue || skip;

  // Gating with reset keeps in_ready low for the whole reset assertion.
  assign in_ready  = reset && !full && !flush;
  assign push      = in_valid && in_ready;
  assign out_data  = empty ? '0 : head;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      issued_cnt  <= '0;
      skipped_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (issue) begin
        issued_cnt <= issued_cnt + 1'b1;
      end
      if (skip) begin
        skipped_cnt <= skipped_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cond_issue_queue.sv
`default_nettype none
// ============================================================================
// tb_cond_issue_queue : two queues (NV dropped / NV issued) driven in lockstep
//                       and compared every cycle against a queue-based model
// Rev 1.0
// ============================================================================
module tb_cond_issue_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic        flags_pending;
  logic        flush;
  logic [31:0] in_data;
  logic [31:0] cpsr;

  logic [1:0]    in_ready;
  logic [1:0]    out_valid;
  logic [DW-1:0] out_data [2];
  logic [CW-1:0] issued   [2];
  logic [CW-1:0] skipped  [2];

  always #5 clk = ~clk;

  cond_issue_queue #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .NV_PASS(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_data(out_data[0]), .cpsr(cpsr), .flags_pending(flags_pending),
    .flush(flush), .issued_cnt(issued[0]), .skipped_cnt(skipped[0])
  );

  cond_issue_queue #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .NV_PASS(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_data(out_data[1]), .cpsr(cpsr), .flags_pending(flags_pending),
    .flush(flush), .issued_cnt(issued[1]), .skipped_cnt(skipped[1])
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mq [2][$];
  int          mi [2];
  int          ms [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h want=%0h", tag, $time, got, exp);
    end
  endtask

  // Conditions come in complementary pairs: bit 0 inverts the even base test.
  function automatic bit ref_pass(input logic [3:0] cond, input logic [3:0] nzcv, input bit nv);
    bit n, z, c, v, base;
    n = nzcv[3]; z = nzcv[2]; c = nzcv[1]; v = nzcv[0];
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'hF) return nv;
    return cond[0] ? !base : base;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mi[k] = 0;
      ms[k] = 0;
    end
  endtask

  task automatic cycle(input bit iv, input logic [31:0] d, input bit ordy,
                       input logic [31:0] cp, input bit fp, input bit fl);
    int          n;
    bit          ev, erdy, eov;
    logic [31:0] hd;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy;
    cpsr = cp; flags_pending = fp; flush = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      n    = mq[k].size();
      hd   = (n != 0) ? mq[k][0] : 32'h0;
      ev   = (n != 0) && !fp && !fl;
      erdy = (n != DEPTH) && !fl;
      eov  = ev && ref_pass(hd[31:28], cp[31:28], k == 1);
      chk($sformatf("in_ready%0d", k), {63'd0, in_ready[k]}, {63'd0, erdy});
      chk($sformatf("out_valid%0d", k), {63'd0, out_valid[k]}, {63'd0, eov});
      chk($sformatf("out_data%0d", k), {32'd0, out_data[k]}, {32'd0, hd});
      chk($sformatf("issued%0d", k), {48'd0, issued[k]}, {48'd0, 16'(mi[k])});
      chk($sformatf("skipped%0d", k), {48'd0, skipped[k]}, {48'd0, 16'(ms[k])});
      if (fl) begin
        mq[k].delete();
      end else begin
        if (ev && eov && ordy) begin
          void'(mq[k].pop_front());
          mi[k]++;
        end else if (ev && !eov) begin
          void'(mq[k].pop_front());
          ms[k]++;
        end
        if (iv && erdy) mq[k].push_back(d);
      end
    end
  endtask

  int saved_iss;
  int saved_skp;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cpsr = '0; flags_pending = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", {62'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {62'd0, out_valid}, 64'd0);
    chk("rst_issued", {48'd0, issued[0]}, 64'd0);
    chk("rst_skipped", {48'd0, skipped[0]}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Z set: EQ issues, NE is dropped
    cycle(1, 32'h0123_4567, 1, 32'h4000_0000, 0, 0);
    cycle(1, 32'h1234_5678, 1, 32'h4000_0000, 0, 0);
    cycle(0, 32'h0, 1, 32'h4000_0000, 0, 0);
    cycle(0, 32'h0, 1, 32'h4000_0000, 0, 0);
    chk("eq_ne_issued", {48'd0, issued[0]}, 64'd1);
    chk("eq_ne_skipped", {48'd0, skipped[0]}, 64'd1);

    // fill with decode stalled; fifth word waits for the first issue
    for (int i = 0; i < 5; i++) cycle(1, 32'hE000_0010 + i, 0, 32'h0, 0, 0);
    chk("full_in_ready", {63'd0, in_ready[0]}, 64'd0);
    cycle(1, 32'hE000_0014, 1, 32'h0, 0, 0);
    cycle(1, 32'hE000_0014, 1, 32'h0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 32'h0, 1, 32'h0, 0, 0);

    // pending flags hold an AL word back
    cycle(1, 32'hE0AA_0001, 1, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 1, 32'h0, 1, 0);
    chk("pend_out_valid", {63'd0, out_valid[0]}, 64'd0);
    cycle(0, 32'h0, 1, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 32'h0, 0, 0);

    // flush three buffered words; counters must hold
    for (int i = 0; i < 3; i++) cycle(1, 32'hE0BB_0000 + i, 0, 32'h0, 1, 0);
    saved_iss = int'(issued[0]);
    saved_skp = int'(skipped[0]);
    cycle(1, 32'hE0CC_0000, 1, 32'h0, 0, 1);
    cycle(0, 32'h0, 1, 32'h0, 0, 0);
    chk("flush_out_valid", {63'd0, out_valid[0]}, 64'd0);
    chk("flush_issued", {48'd0, issued[0]}, 64'(saved_iss));
    chk("flush_skipped", {48'd0, skipped[0]}, 64'(saved_skp));

    // every condition against every NZCV combination
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        cycle(1, {4'(c), 28'h0ABCDEF}, 1, {4'(f), 28'h0}, 0, 0);
        cycle(0, 32'h0, 1, {4'(f), 28'h0}, 0, 0);
      end
    end

    // reset while two words queued and the head is offered
    cycle(1, 32'hE0DD_0001, 0, 32'h0, 0, 0);
    cycle(1, 32'hE0DD_0002, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 0, 32'h0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", {62'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {62'd0, in_ready}, 64'd0);
    chk("midrst_issued", {48'd0, issued[0]}, 64'd0);
    chk("midrst_skipped", {48'd0, skipped[1]}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(1, 32'hE0EE_0001, 1, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 32'h0, 0, 0);

    // random traffic, including flag changes while a head is offered
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 60, $urandom(), $urandom_range(0, 99) < 60,
            {4'($urandom_range(0, 15)), 28'h0}, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
